// File: rtl/data_cache_assoc_pkg.sv
// Shared definitions for the associative data cache: controller states,
// address offset width and the tag-width helper.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  // One-word lines: only the byte offset within the word lies below the index.
  localparam int unsigned OFFSET_BITS = 2;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned set_bits);
    return addr_w - set_bits - OFFSET_BITS;
  endfunction

endpackage

// File: rtl/data_cache_assoc_way.sv
// cache_way: storage for one way of the cache.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset (clears valid/dirty)
//   idx_i                 set index used for both read and write
//   we_i                  install/update the line at idx_i (always marks it valid)
//   dirty_i, tag_i, data_i  values written when we_i is high
//   valid_o, dirty_o, tag_o, data_o  combinational read of the line at idx_i
module cache_way #(
  parameter int unsigned SET_BITS = 6,
  parameter int unsigned TAG_W    = 24,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SET_BITS-1:0] idx_i,
  input  logic                we_i,
  input  logic                dirty_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [DATA_W-1:0]   data_o
);

  localparam int unsigned SETS = 1 << SET_BITS;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= dirty_i;
    end
  end

  // Tag/data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= data_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

endmodule

// File: rtl/data_cache_assoc.sv
// data_cache_assoc: write-back, write-allocate data cache with one-word lines,
// 1- or 2-way (LRU), between the MEM stage and an external req/ack memory port.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   write, MemToRegM             store / load request (both high = store)
//   address, write_data          byte address (bits [1:0] ignored), store data
//   read_data                    load data, combinational on a hit
//   memstall                     pipeline stall request
//   mem_req, mem_we, mem_addr, mem_wdata  registered memory request (we=1 writeback)
//   mem_rdata, mem_ack           fill data and one-cycle completion pulse
//   hit_cnt, miss_cnt            saturating access counters
module data_cache_assoc
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SET_BITS = 6,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              MemToRegM,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              memstall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned TAG_W = tag_width(ADDR_W, SET_BITS);
  localparam int unsigned SETS  = 1 << SET_BITS;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   miss_addr_q;
  logic                victim_q;
  logic                retry_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic                access;
  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    req_tag, miss_tag;

  logic [WAYS-1:0]     way_valid, way_dirty, way_we;
  logic [TAG_W-1:0]    way_tag  [WAYS];
  logic [DATA_W-1:0]   way_data [WAYS];

  logic                hit, hit_way;
  logic                victim_sel, victim_found, lru_victim;
  logic                wr_dirty;
  logic [TAG_W-1:0]    wr_tag;
  logic [DATA_W-1:0]   wr_data;
  logic                stall, count_hit, count_miss;
  logic [DATA_W-1:0]   rdata;

  assign access   = write | MemToRegM;
  // Outside IDLE the latched miss address drives the arrays, not the held inputs.
  assign idx      = (state_q == IDLE) ? address[SET_BITS+OFFSET_BITS-1:OFFSET_BITS]
                                      : miss_addr_q[SET_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign req_tag  = address[ADDR_W-1:SET_BITS+OFFSET_BITS];
  assign miss_tag = miss_addr_q[ADDR_W-1:SET_BITS+OFFSET_BITS];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way #(
      .SET_BITS(SET_BITS),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
    ) u_way (
      .clk_i  (clk),
      .rst_i  (reset),
      .idx_i  (idx),
      .we_i   (way_we[g]),
      .dirty_i(wr_dirty),
      .tag_i  (wr_tag),
      .data_i (wr_data),
      .valid_o(way_valid[g]),
      .dirty_o(way_dirty[g]),
      .tag_o  (way_tag[g]),
      .data_o (way_data[g])
    );
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // First invalid way wins (way0 first); otherwise the LRU way.
  always_comb begin
    victim_sel   = lru_victim;
    victim_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !victim_found) begin
        victim_sel   = 1'(w);
        victim_found = 1'b1;
      end
    end
  end

  if (WAYS == 2) begin : g_lru
    // One bit per set naming the least recently used way.
    logic [SETS-1:0] lru_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lru_q <= '0;
      end else if (state_q == IDLE && access && hit) begin
        lru_q[idx] <= ~hit_way;
      end else if (state_q == FILL && mem_ack) begin
        lru_q[idx] <= ~victim_q;
      end
    end
    assign lru_victim = lru_q[idx];
  end else begin : g_no_lru
    assign lru_victim = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    way_we     = '0;
    wr_dirty   = 1'b0;
    wr_tag     = req_tag;
    wr_data    = write_data;
    stall      = 1'b0;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    rdata      = '0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (hit) begin
            rdata     = way_data[hit_way];
            count_hit = ~retry_q;
            if (write) begin
              way_we[hit_way] = 1'b1;
              wr_dirty        = 1'b1;
            end
          end else begin
            stall      = 1'b1;
            count_miss = 1'b1;
            state_d    = way_dirty[victim_sel] ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        stall = 1'b1;
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        stall = 1'b1;
        if (mem_ack) begin
          way_we[victim_q] = 1'b1;
          wr_dirty         = 1'b0;
          wr_tag           = miss_tag;
          wr_data          = mem_rdata;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      victim_q    <= 1'b0;
      retry_q     <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= (state_q == FILL) && mem_ack;
      if (count_hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (count_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (access && !hit) begin
            miss_addr_q <= address;
            victim_q    <= victim_sel;
            mem_req_q   <= 1'b1;
            if (way_dirty[victim_sel]) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {way_tag[victim_sel], idx, {OFFSET_BITS{1'b0}}};
              mem_wdata_q <= way_data[victim_sel];
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= {miss_addr_q[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end
        end
        FILL: begin
          if (mem_ack) mem_req_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Reset must clear the combinational outputs at once, not just at the next edge.
  assign memstall  = stall & ~reset;
  assign read_data = reset ? '0 : rdata;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_data_cache_assoc.sv
module tb_data_cache_assoc;

  logic        clk = 1'b0;
  logic        reset;
  logic        write, rd;
  logic [31:0] address, write_data, mem_rdata;
  logic        mem_ack;
  logic        sel;  // 0: two-way instance, 1: direct-mapped instance

  always #5 clk = ~clk;

  logic [31:0] rd0, rd1, addr0, addr1, wd0, wd1, hc0, hc1, mc0, mc1;
  logic        ms0, ms1, req0, req1, we0, we1;

  data_cache_assoc #(.WAYS(2)) dut0 (
    .clk(clk), .reset(reset), .write(write & ~sel), .MemToRegM(rd & ~sel),
    .address(address), .write_data(write_data), .read_data(rd0), .memstall(ms0),
    .mem_req(req0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack & ~sel), .hit_cnt(hc0), .miss_cnt(mc0)
  );

  data_cache_assoc #(.WAYS(1)) dut1 (
    .clk(clk), .reset(reset), .write(write & sel), .MemToRegM(rd & sel),
    .address(address), .write_data(write_data), .read_data(rd1), .memstall(ms1),
    .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack & sel), .hit_cnt(hc1), .miss_cnt(mc1)
  );

  logic [31:0] o_rd, o_addr, o_wd, o_hc, o_mc;
  logic        o_ms, o_req, o_we;
  assign o_rd   = sel ? rd1   : rd0;
  assign o_ms   = sel ? ms1   : ms0;
  assign o_req  = sel ? req1  : req0;
  assign o_we   = sel ? we1   : we0;
  assign o_addr = sel ? addr1 : addr0;
  assign o_wd   = sel ? wd1   : wd0;
  assign o_hc   = sel ? hc1   : hc0;
  assign o_mc   = sel ? mc1   : mc0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem_model [logic [31:0]];
  int          ack_delay = 2;
  int          exp_hits  = 0;
  int          exp_miss  = 0;

  task automatic push_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    exp_txn.push_back(t);
  endtask

  // Memory responder: pops the expected transaction, checks the request stays
  // stable while waiting, then acks; writebacks update the memory model.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && o_req) begin
        txn_t t, e;
        logic abort;
        t.we = o_we; t.addr = o_addr; t.wdata = o_wd;
        abort = 1'b0;
        check("req_stall", o_ms, 1);
        if (exp_txn.size() == 0) begin
          check("txn_unexpected_addr", t.addr, 32'hdead_beef);
        end else begin
          e = exp_txn.pop_front();
          check("txn_we", t.we, e.we);
          check("txn_addr", t.addr, e.addr);
          if (e.we) check("txn_wdata", t.wdata, e.wdata);
        end
        for (int i = 0; i < ack_delay; i++) begin
          @(negedge clk);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          check("hold_req", o_req, 1);
          check("hold_we", o_we, t.we);
          check("hold_addr", o_addr, t.addr);
          check("hold_wdata", o_wd, t.wdata);
          check("hold_stall", o_ms, 1);
        end
        if (!abort) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model.exists(t.addr) ? mem_model[t.addr] : 32'h0;
          if (t.we) mem_model[t.addr] = t.wdata;
          @(posedge clk);
          #1;
          mem_ack   = 1'b0;
          mem_rdata = '0;
          if (!t.we) begin
            @(negedge clk);
            check("fill_done_stall", o_ms, 0);
            check("fill_done_req", o_req, 0);
          end
        end
      end
    end
  end

  // One access: checks hit/miss, load data on the completing cycle, and counters.
  task automatic access(input logic wr, input logic ld, input logic [31:0] a,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input logic miss);
    int cyc;
    @(posedge clk);
    #1;
    write = wr; rd = ld; address = a; write_data = wdata;
    if (ld && !wr) exp_rd.push_back(exp_data);
    if (miss) exp_miss++; else exp_hits++;
    @(negedge clk);
    check("miss_flag", o_ms, miss);
    cyc = 0;
    while (o_ms && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("access_done", o_ms, 0);
    check("idle_req", o_req, 0);
    if (ld && !wr) check("read_data", o_rd, exp_rd.pop_front());
    @(posedge clk);
    #1;
    write = 1'b0; rd = 1'b0;
    check("hit_cnt", o_hc, exp_hits);
    check("miss_cnt", o_mc, exp_miss);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sel = 1'b0; write = 1'b0; rd = 1'b0;
    address = '0; write_data = '0;
    #22 reset = 1'b0;
    @(negedge clk);
    check("rst_stall", o_ms, 0);
    check("rst_req", o_req, 0);
    check("rst_we", o_we, 0);
    check("rst_addr", o_addr, 0);
    check("rst_rdata", o_rd, 0);
    check("rst_hits", o_hc, 0);
    check("rst_miss", o_mc, 0);

    // Cold store miss, then load hit.
    push_txn(1'b0, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h0, 32'hffff_ffff, 32'h0, 1'b1);
    access(1'b0, 1'b1, 32'h0, 32'h0, 32'hffff_ffff, 1'b0);

    // Two-way LRU: evict the dirty LRU line of set 3 with a slow writeback.
    push_txn(1'b0, 32'h000c, 32'h0);
    access(1'b1, 1'b0, 32'h000c, 32'haaaa_aaaa, 32'h0, 1'b1);
    push_txn(1'b0, 32'h400c, 32'h0);
    access(1'b1, 1'b0, 32'h400c, 32'hbbbb_bbbb, 32'h0, 1'b1);
    access(1'b0, 1'b1, 32'h000c, 32'h0, 32'haaaa_aaaa, 1'b0);
    ack_delay = 20;
    push_txn(1'b1, 32'h400c, 32'hbbbb_bbbb);
    push_txn(1'b0, 32'h800c, 32'h0);
    access(1'b1, 1'b0, 32'h800c, 32'hcccc_cccc, 32'h0, 1'b1);
    ack_delay = 2;
    access(1'b0, 1'b1, 32'h000c, 32'h0, 32'haaaa_aaaa, 1'b0);
    access(1'b0, 1'b1, 32'h800c, 32'h0, 32'hcccc_cccc, 1'b0);
    // 0x800c is now MRU, then 0x000c touched: 0x800c (dirty) is evicted.
    access(1'b0, 1'b1, 32'h000c, 32'h0, 32'haaaa_aaaa, 1'b0);
    push_txn(1'b1, 32'h800c, 32'hcccc_cccc);
    push_txn(1'b0, 32'h400c, 32'h0);
    access(1'b0, 1'b1, 32'h400c, 32'h0, 32'hbbbb_bbbb, 1'b1);

    // Reset in the middle of a writeback of 0x000c.
    ack_delay = 20;
    push_txn(1'b1, 32'h000c, 32'haaaa_aaaa);
    @(posedge clk);
    #1;
    write = 1'b1; address = 32'h800c; write_data = 32'hdddd_dddd;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    write = 1'b0;
    #1;
    check("midrst_req", o_req, 0);
    check("midrst_stall", o_ms, 0);
    check("midrst_miss", o_mc, 0);
    check("midrst_hits", o_hc, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    exp_txn.delete();
    ack_delay = 2;
    exp_hits = 0;
    exp_miss = 0;
    push_txn(1'b0, 32'h000c, 32'h0);
    access(1'b0, 1'b1, 32'h000c, 32'h0, 32'h0, 1'b1);

    // Direct-mapped instance: conflicting lines always miss.
    sel = 1'b1;
    do_reset();
    push_txn(1'b0, 32'h000c, 32'h0);
    access(1'b1, 1'b0, 32'h000c, 32'h1111_1111, 32'h0, 1'b1);
    push_txn(1'b1, 32'h000c, 32'h1111_1111);
    push_txn(1'b0, 32'h400c, 32'h0);
    access(1'b0, 1'b1, 32'h400c, 32'h0, 32'hbbbb_bbbb, 1'b1);
    push_txn(1'b0, 32'h000c, 32'h0);
    access(1'b0, 1'b1, 32'h000c, 32'h0, 32'h1111_1111, 1'b1);

    repeat (3) @(posedge clk);
    check("txn_queue_left", exp_txn.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache_assoc.md
Name: data_cache_assoc

Overview:
Parametrised, write-back, write-allocate data cache with one-word lines. It sits between the MEM pipeline stage and an external memory port. Hits complete in the same cycle. Misses raise memstall while the victim line is written back (if dirty) and the missing line is filled through a req/ack handshake. Associativity, set count and data width are configurable, and hit/miss counters are included.

Parameters:
DATA_W, 32, data word width.
ADDR_W, 32, byte address width.
SET_BITS, 6, log2(number of sets); 64 sets by default.
WAYS, 2, associativity; legal values are 1 (direct-mapped) or 2 (LRU).
CNT_W, 32, width of the hit and miss counters.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
write  in  1  store request this cycle.
MemToRegM  in  1  load request this cycle.
address  in  ADDR_W  byte address; bits [1:0] are ignored.
write_data  in  DATA_W  store data.
read_data  out  DATA_W  load data; combinational on a hit.
memstall  out  1  pipeline stall request.
mem_req  out  1  external memory request; registered.
mem_we  out  1  1 = writeback, 0 = fill.
mem_addr  out  ADDR_W  word-aligned memory address.
mem_wdata  out  DATA_W  writeback data.
mem_rdata  in  DATA_W  fill data; valid only when mem_ack is high.
mem_ack  in  1  one-cycle completion pulse from memory.
hit_cnt  out  CNT_W  saturating hit counter.
miss_cnt  out  CNT_W  saturating miss counter.

Behaviour:
- Address split: index = address[SET_BITS+1:2]; tag = address[ADDR_W-1:SET_BITS+2].
- Access: an access is any cycle with write or MemToRegM high. If both are high, the cycle is a store and read_data still shows the pre-store word.
- Reset (async): clears all valid, dirty and LRU bits, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, memstall=0, read_data=0, both counters=0.
- Reset mid-transaction: aborts the transaction immediately. Dirty data in flight is lost; this is intentional.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE, hit:
  - memstall=0; read_data = data of the hit way.
  - A store updates the word and sets dirty at the clock edge.
  - The hit way becomes MRU.
  - hit_cnt increments, unless the cycle is the retry that immediately follows a fill.
- IDLE, miss:
  - memstall=1 combinationally in the same cycle.
  - The request address is latched into miss_addr.
  - miss_cnt increments once.
  - Victim selection: the first invalid way (way0 has priority), otherwise the LRU way.
  - If the victim is dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data.
  - All four outputs are held stable until mem_ack, then go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={miss_addr[ADDR_W-1:2], 2'b00}.
  - On mem_ack: install the victim way with valid=1, dirty=0, tag from miss_addr, data=mem_rdata; then go to IDLE.
- Stall timing: memstall is 1 throughout WRITEBACK and FILL, including the ack cycle. The cycle after the fill ack is a retry in IDLE; it hits, and any store completes there.
- mem_req: drops in the cycle after the final ack. There are no back-to-back transactions without passing through IDLE.
- Ignored inputs: mem_ack in IDLE. Input changes during a stall; the pipeline holds its inputs, and miss_addr governs the fill.
- WAYS=1: LRU logic is absent and the single way is always the victim.
- Counters: saturate at all-ones and do not wrap.

Decomposition:
- Package cache_pkg holds:
  - the state enum (IDLE, WRITEBACK, FILL);
  - OFFSET_BITS=2;
  - a function computing the tag width from ADDR_W and SET_BITS.
- Sub-module cache_way: one way's valid, dirty, tag and data arrays, with read and write ports. The top level instantiates it WAYS times through a generate loop. The FSM, LRU bits and counters stay in the top level.

Test Plan:
1. Cold store miss:
   - Stimulus: reset, then write=1, address=0x0, write_data=0xffffffff.
   - Required: memstall=1 in the same cycle. The next cycle shows mem_req=1, mem_we=0, mem_addr=0x0. Ack with mem_rdata=0. In the retry cycle memstall=0, the line is dirty, and miss_cnt=1.
2. Load hit:
   - Stimulus: MemToRegM=1, address=0x0.
   - Required: read_data=0xffffffff, memstall=0, mem_req=0, hit_cnt increments.
3. Two-way LRU writeback:
   - Stimulus: store 0xaaaaaaaa to 0x000c and 0xbbbbbbbb to 0x400c (both set 3). Load 0x000c, which hits. Then store 0xcccccccc to 0x800c.
   - Required: a WRITEBACK transaction with mem_we=1, mem_addr=0x400c, mem_wdata=0xbbbbbbbb. Then a FILL of 0x800c. A later load of 0x000c hits with read_data 0xaaaaaaaa.
4. Slow memory:
   - Stimulus: mem_ack delayed 20 cycles.
   - Required: mem_req, mem_addr and mem_wdata are held constant and memstall stays 1 for every cycle until ack. The fill completes exactly one cycle after ack.
5. Reset mid-WRITEBACK:
   - Stimulus: assert reset during a WRITEBACK.
   - Required: mem_req=0 and memstall=0 asynchronously, before the next edge. A subsequent load of 0x000c misses and miss_cnt restarts at 1.
6. WAYS=1 instance:
   - Stimulus: store 0x000c, then load 0x400c, then load 0x000c.
   - Required: every access misses, and the first eviction writes back 0x000c.
